// File: rtl/cache_response_merge.sv
// cache_response_merge
//
// Response side of the engine-to-cache request path. Every request the cache
// accepts is recorded (is_write, meta, data) in a pending FIFO in issue order.
// Cache read responses arrive strictly in request order. Each one is paired with
// the oldest pending entry to form a merged packet, which is held in a single
// registered output stage until the engine takes it.
//
// Ports
//   ap_clk, ap_rst_n   clock, asynchronous active-low reset
//   req_valid/ready    request issued to the cache / a pending slot is free
//   req_is_write       request is a memory write (data passes through)
//   req_meta           meta echoed on the merged packet
//   req_data           request data, field i at [i*DATA_W +: DATA_W]
//   resp_valid         cache response strobe (no backpressure)
//   resp_rdata         cache read data
//   pkt_out_valid/ready, pkt_out_meta, pkt_out_data   merged packet to the engine
//   fifo_empty         nothing pending and the output stage is empty
//   fifo_prog_full     pending occupancy >= PROG_FULL_THRESH (registered)
//   resp_orphan        sticky: a response arrived with no request waiting for it
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A valid source holds valid and its payload stable until the
// transfer; ready never depends combinationally on valid. resp_valid is a
// strobe and is always taken (or flagged as an orphan).

module cache_response_merge #(
  parameter int DATA_W           = 32,
  parameter int NUM_FIELDS       = 4,
  parameter int META_W           = 128,
  parameter int PENDING_DEPTH    = 16,
  parameter int PROG_FULL_THRESH = 12
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,

  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_is_write,
  input  logic [META_W-1:0]            req_meta,
  input  logic [NUM_FIELDS*DATA_W-1:0] req_data,

  input  logic                         resp_valid,
  input  logic [DATA_W-1:0]            resp_rdata,

  output logic                         pkt_out_valid,
  input  logic                         pkt_out_ready,
  output logic [META_W-1:0]            pkt_out_meta,
  output logic [NUM_FIELDS*DATA_W-1:0] pkt_out_data,

  output logic                         fifo_empty,
  output logic                         fifo_prog_full,
  output logic                         resp_orphan
);

  localparam int PKT_W   = NUM_FIELDS * DATA_W;
  localparam int ENTRY_W = 1 + META_W + PKT_W;
  localparam int CW      = $clog2(PENDING_DEPTH + 1);
  localparam int PW      = $clog2(PENDING_DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(PENDING_DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(PROG_FULL_THRESH);

  // ---------------------------------------------------------------------------
  // Pending FIFO: {is_write, meta, data}
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] pend_mem [PENDING_DEPTH];
  logic [PW-1:0]      pend_wr_ptr;
  logic [PW-1:0]      pend_rd_ptr;
  logic [CW-1:0]      pending_count;
  logic [CW-1:0]      pending_next;

  // ---------------------------------------------------------------------------
  // Rdata FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]  rdata_mem [PENDING_DEPTH];
  logic [PW-1:0]      rdata_wr_ptr;
  logic [PW-1:0]      rdata_rd_ptr;
  logic [CW-1:0]      rdata_count;
  logic [CW-1:0]      rdata_next;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic               req_push;
  logic [CW-1:0]      pend_avail;
  logic               rdata_push;
  logic               pend_head_valid;
  logic               rdata_head_valid;
  logic               out_free;
  logic               load;

  logic [ENTRY_W-1:0] pend_head;
  logic               head_is_write;
  logic [META_W-1:0]  head_meta;
  logic [PKT_W-1:0]   head_data;
  logic [DATA_W-1:0]  rdata_head;
  logic [PKT_W-1:0]   merged_data;

  assign req_ready = (pending_count < DEPTH_C);
  assign req_push  = req_valid && req_ready;

  // A request accepted this cycle already counts as pending, so a response in
  // the same cycle as its request is legal and is not flagged as an orphan.
  assign pend_avail = pending_count + CW'(req_push);
  assign rdata_push = resp_valid && (rdata_count < pend_avail);

  // Empty FIFOs bypass their incoming word straight to the head. The word is
  // still written to memory; when it is consumed in the same cycle both
  // pointers advance together, so the memory copy is never read.
  assign pend_head_valid  = (pending_count != '0) || req_push;
  assign rdata_head_valid = (rdata_count != '0) || rdata_push;

  always_comb begin
    pend_head = pend_mem[pend_rd_ptr];
    if (pending_count == '0) begin
      pend_head = {req_is_write, req_meta, req_data};
    end
  end

  always_comb begin
    rdata_head = rdata_mem[rdata_rd_ptr];
    if (rdata_count == '0) begin
      rdata_head = resp_rdata;
    end
  end

  assign head_is_write = pend_head[ENTRY_W-1];
  assign head_meta     = pend_head[PKT_W +: META_W];
  assign head_data     = pend_head[PKT_W-1:0];

  // Reads shift the request fields up by one and put the cache data in field 0;
  // the top request field falls off. Writes echo their data untouched.
  always_comb begin
    merged_data = head_data;
    if (!head_is_write) begin
      merged_data = {head_data[(NUM_FIELDS-1)*DATA_W-1:0], rdata_head};
    end
  end

  assign out_free = !pkt_out_valid || pkt_out_ready;
  assign load     = pend_head_valid && rdata_head_valid && out_free;

  assign pending_next = pending_count + CW'(req_push) - CW'(load);
  assign rdata_next   = rdata_count + CW'(rdata_push) - CW'(load);

  // ---------------------------------------------------------------------------
  // Storage (no reset needed: only entries below the counts are ever read)
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (req_push) begin
      pend_mem[pend_wr_ptr] <= {req_is_write, req_meta, req_data};
    end
    if (rdata_push) begin
      rdata_mem[rdata_wr_ptr] <= resp_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, counts and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pend_wr_ptr    <= '0;
      pend_rd_ptr    <= '0;
      pending_count  <= '0;
      rdata_wr_ptr   <= '0;
      rdata_rd_ptr   <= '0;
      rdata_count    <= '0;
      fifo_prog_full <= 1'b0;
      resp_orphan    <= 1'b0;
    end else begin
      if (req_push) begin
        pend_wr_ptr <= pend_wr_ptr + PW'(1);
      end
      if (rdata_push) begin
        rdata_wr_ptr <= rdata_wr_ptr + PW'(1);
      end
      if (load) begin
        pend_rd_ptr  <= pend_rd_ptr + PW'(1);
        rdata_rd_ptr <= rdata_rd_ptr + PW'(1);
      end
      pending_count  <= pending_next;
      rdata_count    <= rdata_next;
      fifo_prog_full <= (pending_next >= THRESH_C);
      if (resp_valid && !rdata_push) begin
        resp_orphan <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pkt_out_valid <= 1'b0;
      pkt_out_meta  <= '0;
      pkt_out_data  <= '0;
    end else if (load) begin
      pkt_out_valid <= 1'b1;
      pkt_out_meta  <= head_meta;
      pkt_out_data  <= merged_data;
    end else if (pkt_out_ready) begin
      pkt_out_valid <= 1'b0;
    end
  end

  assign fifo_empty = (pending_count == '0) && !pkt_out_valid;

endmodule

// File: tb/tb_cache_response_merge.sv
module tb_cache_response_merge;

  localparam int DATA_W     = 32;
  localparam int NUM_FIELDS = 4;
  localparam int META_W     = 128;
  localparam int DEPTH      = 16;
  localparam int THRESH     = 12;
  localparam int PKT_W      = NUM_FIELDS * DATA_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_is_write = 1'b0;
  logic [META_W-1:0]   req_meta = '0;
  logic [PKT_W-1:0]    req_data = '0;
  logic                resp_valid = 1'b0;
  logic [DATA_W-1:0]   resp_rdata = '0;
  logic                pkt_out_valid;
  logic                pkt_out_ready = 1'b1;
  logic [META_W-1:0]   pkt_out_meta;
  logic [PKT_W-1:0]    pkt_out_data;
  logic                fifo_empty;
  logic                fifo_prog_full;
  logic                resp_orphan;

  cache_response_merge #(
    .DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .META_W(META_W),
    .PENDING_DEPTH(DEPTH), .PROG_FULL_THRESH(THRESH)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_meta(req_meta), .req_data(req_data),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
    .pkt_out_meta(pkt_out_meta), .pkt_out_data(pkt_out_data),
    .fifo_empty(fifo_empty), .fifo_prog_full(fifo_prog_full),
    .resp_orphan(resp_orphan)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: queues of outstanding requests and of unmatched read data
  // ---------------------------------------------------------------------------
  typedef struct {
    logic              w;
    logic [META_W-1:0] meta;
    logic [PKT_W-1:0]  data;
  } ent_t;

  ent_t                     pq[$];
  logic [DATA_W-1:0]        rq[$];
  logic [META_W+PKT_W-1:0]  exp_q[$];
  logic                     m_out_v;
  logic [META_W-1:0]        m_out_meta;
  logic [PKT_W-1:0]         m_out_data;
  logic                     m_orphan;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pq.delete();
    rq.delete();
    exp_q.delete();
    m_out_v    = 1'b0;
    m_out_meta = '0;
    m_out_data = '0;
    m_orphan   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    ent_t e;
    ent_t h;
    logic [DATA_W-1:0] r;
    logic [META_W+PKT_W-1:0] x;
    bit out_free;
    if (m_out_v && pkt_out_ready) begin
      x = exp_q.pop_front();
      chk("delivered_meta", pkt_out_meta, x[PKT_W +: META_W]);
      chk("delivered_data", pkt_out_data, x[PKT_W-1:0]);
    end
    out_free = !m_out_v || pkt_out_ready;
    if (req_valid && pq.size() < DEPTH) begin
      e.w = req_is_write; e.meta = req_meta; e.data = req_data;
      pq.push_back(e);
    end
    if (resp_valid) begin
      if (rq.size() < pq.size()) rq.push_back(resp_rdata);
      else m_orphan = 1'b1;
    end
    if (out_free) begin
      if (pq.size() > 0 && rq.size() > 0) begin
        h = pq.pop_front();
        r = rq.pop_front();
        m_out_meta = h.meta;
        if (h.w) m_out_data = h.data;
        else begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            if (i == 0) m_out_data[0 +: DATA_W] = r;
            else m_out_data[i*DATA_W +: DATA_W] = h.data[(i-1)*DATA_W +: DATA_W];
          end
        end
        m_out_v = 1'b1;
        exp_q.push_back({m_out_meta, m_out_data});
      end else begin
        m_out_v = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("pkt_out_valid", pkt_out_valid, m_out_v);
    if (m_out_v) begin
      chk("pkt_out_meta", pkt_out_meta, m_out_meta);
      chk("pkt_out_data", pkt_out_data, m_out_data);
    end
    chk("req_ready", req_ready, pq.size() < DEPTH);
    chk("fifo_empty", fifo_empty, (pq.size() == 0) && !m_out_v);
    chk("fifo_prog_full", fifo_prog_full, pq.size() >= THRESH);
    chk("resp_orphan", resp_orphan, m_orphan);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    model_step();
    @(posedge ap_clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_is_write = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic drive_req(input logic w, input logic [META_W-1:0] m, input logic [PKT_W-1:0] d);
    req_valid = 1'b1; req_is_write = w; req_meta = m; req_data = d;
  endtask

  task automatic drive_resp(input logic [DATA_W-1:0] r);
    resp_valid = 1'b1; resp_rdata = r;
  endtask

  task automatic pulse_reset();
    idle();
    #2 ap_rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs();
    chk("rst_meta_zero", pkt_out_meta, '0);
    chk("rst_data_zero", pkt_out_data, '0);
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
  endtask

  logic [META_W-1:0] bp_meta [8];
  localparam logic [META_W-1:0] M1 = 128'h1111_2222_3333_4444_5555_6666_7777_0001;

  // ---------------------------------------------------------------------------
  // Directed sequence followed by a random phase
  // ---------------------------------------------------------------------------
  initial begin
    model_clear();
    #12;
    check_outputs();
    chk("rst_meta_zero", pkt_out_meta, '0);
    chk("rst_data_zero", pkt_out_data, '0);
    #5 ap_rst_n = 1'b1;
    pkt_out_ready = 1'b1;
    idle();
    tick();
    chk("ready_after_reset", req_ready, 1'b1);

    // Single read: request at t-1, response at t, packet visible at t+1
    drive_req(1'b0, M1, 128'h000000A3_000000A2_000000A1_000000A0);
    tick();
    idle();
    drive_resp(32'h0000_0055);
    tick();
    idle();
    chk("read_valid", pkt_out_valid, 1'b1);
    chk("read_meta", pkt_out_meta, M1);
    chk("read_data", pkt_out_data, 128'h000000A2_000000A1_000000A0_00000055);
    tick();

    // Write passthrough: rdata ignored
    drive_req(1'b1, 128'h5A5A, 128'h00000004_00000003_00000002_00000001);
    tick();
    idle();
    drive_resp(32'h0000_DEAD);
    tick();
    idle();
    chk("write_data", pkt_out_data, 128'h00000004_00000003_00000002_00000001);
    tick();

    // Request and response in the same cycle on an empty pipeline
    drive_req(1'b0, 128'hBEEF, 128'h00000013_00000012_00000011_00000010);
    drive_resp(32'h0000_0077);
    tick();
    idle();
    chk("same_cycle_data", pkt_out_data, 128'h00000012_00000011_00000010_00000077);
    tick();

    // Full: 16 requests, no responses
    for (int i = 0; i < DEPTH; i++) begin
      drive_req($urandom_range(0, 1), rand128(), rand128());
      tick();
      if (i == THRESH - 2) chk("prog_full_below", fifo_prog_full, 1'b0);
      if (i == THRESH - 1) chk("prog_full_at", fifo_prog_full, 1'b1);
    end
    chk("full_not_ready", req_ready, 1'b0);
    drive_req(1'b0, rand128(), rand128());
    tick();
    idle();
    drive_resp($urandom());
    tick();
    idle();
    chk("ready_after_pop", req_ready, 1'b1);
    chk("pkt_after_full", pkt_out_valid, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive_resp($urandom());
      tick();
    end
    idle();
    tick();
    tick();
    chk("empty_after_full", fifo_empty, 1'b1);

    // Backpressure: 20 cycles with pkt_out_ready low
    pkt_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bp_meta[i] = rand128();
      drive_req(1'b0, bp_meta[i], rand128());
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      drive_resp($urandom());
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_meta", pkt_out_meta, bp_meta[0]);
      tick();
    end
    pkt_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_stream_valid", pkt_out_valid, 1'b1);
      chk("bp_stream_order", pkt_out_meta, bp_meta[k]);
      tick();
    end
    chk("bp_drained", pkt_out_valid, 1'b0);

    // Orphan response
    drive_resp(32'h0BAD_0BAD);
    tick();
    idle();
    chk("orphan_set", resp_orphan, 1'b1);
    chk("orphan_no_pkt", pkt_out_valid, 1'b0);
    tick();
    tick();
    chk("orphan_sticky", resp_orphan, 1'b1);

    // Reset with 5 outstanding requests; late responses become orphans
    pulse_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, rand128(), rand128());
      tick();
    end
    idle();
    pulse_reset();
    chk("midrst_empty", fifo_empty, 1'b1);
    chk("midrst_valid", pkt_out_valid, 1'b0);
    chk("midrst_orphan_clr", resp_orphan, 1'b0);
    tick();
    chk("midrst_ready", req_ready, 1'b1);
    drive_resp($urandom());
    tick();
    idle();
    chk("late_resp_orphan", resp_orphan, 1'b1);
    pulse_reset();
    tick();

    // Random traffic with legal responses and random backpressure
    for (int c = 0; c < 2000; c++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_is_write = ($urandom_range(0, 3) == 0);
      req_meta = rand128();
      req_data = rand128();
      pkt_out_ready = ($urandom_range(0, 9) < 7);
      resp_valid = (pq.size() > rq.size()) && ($urandom_range(0, 2) != 0);
      resp_rdata = $urandom();
      tick();
    end
    idle();
    pkt_out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      resp_valid = (pq.size() > rq.size());
      resp_rdata = $urandom();
      tick();
    end
    idle();
    tick();
    chk("final_empty", fifo_empty, 1'b1);
    chk("final_no_orphan", resp_orphan, 1'b0);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
